adder_result_fifo: RTL and testbench

ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

---
 rtl/adder_result_fifo.sv | 112 +++++++++++
 tb/tb_adder_result_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/adder_result_fifo.sv
// adder_result_fifo: first-word-fall-through FIFO for {carry,sum} adder results.
// Optional feature: define ADDER_RESULT_FIFO_CARRY_CNT_EN to enable carry_cnt.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   upstream result present
//   in_s/in_c  upstream sum / carry
//   in_ready   FIFO can accept (not full)
//   out_valid  head entry present (not empty)
//   out_s/out_c head entry sum / carry, zero when empty
//   out_ready  downstream consumes head
//   count      occupancy 0..DEPTH
//   drop       sticky: a result arrived while full and was lost
//   carry_cnt  saturating count of accepted entries with carry set
//              (constant 0 unless ADDER_RESULT_FIFO_CARRY_CNT_EN)
module adder_result_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [3:0]               in_s,
    input  logic                     in_c,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [3:0]               out_s,
    output logic                     out_c,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop,
    output logic [7:0]               carry_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_drop;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_head;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Push is gated by full only: a pop in the same cycle does not
    // free a slot for the incoming word.
    assign w_push  = in_valid && !w_full;
    assign w_pop   = !w_empty && out_ready;
    assign w_head  = r_mem[r_rptr];

    // Storage is not reset; it is masked by out_valid on the outputs.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_c, in_s};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_drop  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (in_valid && w_full) begin
                r_drop <= 1'b1;
            end
        end
    end

`ifdef ADDER_RESULT_FIFO_CARRY_CNT_EN
    logic [7:0] r_carry_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry_cnt <= '0;
        end else if (w_push && in_c && (r_carry_cnt != 8'hFF)) begin
            r_carry_cnt <= r_carry_cnt + 8'd1;
        end
    end

    assign carry_cnt = r_carry_cnt;
`else
    assign carry_cnt = 8'd0;
`endif

    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_s     = w_empty ? 4'd0 : w_head[3:0];
    assign out_c     = w_empty ? 1'b0 : w_head[4];
    assign count     = r_count;
    assign drop      = r_drop;

endmodule

// File: tb/tb_adder_result_fifo.sv
// tb_adder_result_fifo: directed checks for adder_result_fifo (DEPTH=4).
// Honors ADDER_RESULT_FIFO_CARRY_CNT_EN for the carry counter expectation.
module tb_adder_result_fifo;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_s;
    logic       in_c;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_s;
    logic       out_c;
    logic       out_ready;
    logic [2:0] count;
    logic       drop;
    logic [7:0] carry_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    adder_result_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_s      (in_s),
        .in_c      (in_c),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_s     (out_s),
        .out_c     (out_c),
        .out_ready (out_ready),
        .count     (count),
        .drop      (drop),
        .carry_cnt (carry_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_s      = 4'd0;
        in_c      = 1'b0;
        out_ready = 1'b0;
        #3;
        chk("rst_count", count, 0);
        chk("rst_ovalid", out_valid, 0);
        chk("rst_iready", in_ready, 1);
        chk("rst_out_s", out_s, 0);
        chk("rst_out_c", out_c, 0);
        chk("rst_drop", drop, 0);
        chk("rst_ccnt", carry_cnt, 0);
        step();
        rst = 1'b0;

        // Three pushes, then drain in order
        in_valid = 1'b1; in_s = 4'h3; in_c = 1'b0;
        step();
        chk("lat1_valid", out_valid, 1);
        chk("lat1_s", out_s, 4'h3);
        chk("lat1_count", count, 1);
        in_s = 4'hF; in_c = 1'b1;
        step();
        in_s = 4'h8; in_c = 1'b0;
        step();
        in_valid = 1'b0;
        chk("p3_count", count, 3);
        chk("p3_valid", out_valid, 1);
        chk("p3_s", out_s, 4'h3);
        chk("p3_c", out_c, 0);
        out_ready = 1'b1;
        step();
        chk("d1_s", out_s, 4'hF);
        chk("d1_c", out_c, 1);
        chk("d1_count", count, 2);
        step();
        chk("d2_s", out_s, 4'h8);
        chk("d2_c", out_c, 0);
        chk("d2_count", count, 1);
        step();
        chk("d3_count", count, 0);
        chk("d3_valid", out_valid, 0);
        chk("d3_s", out_s, 0);

        // Pop on empty has no effect
        for (int i = 0; i < 3; i++) begin
            step();
            chk("uf_count", count, 0);
            chk("uf_valid", out_valid, 0);
            chk("uf_s", out_s, 0);
        end
        chk("uf_iready", in_ready, 1);
        out_ready = 1'b0;

        // Overfill: 5 pushes into DEPTH=4
        in_valid = 1'b1; in_c = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            in_s = 4'(i);
            step();
        end
        chk("full_iready", in_ready, 0);
        chk("full_count", count, 4);
        chk("full_drop0", drop, 0);
        in_s = 4'd5;
        step();
        chk("ovf_drop", drop, 1);
        chk("ovf_count", count, 4);
        chk("ovf_head", out_s, 4'd1);
        // Full with out_ready: pop only, input still refused
        in_s = 4'd6;
        out_ready = 1'b1;
        #1;
        chk("full_rdy_iready", in_ready, 0);
        step();
        chk("full_pop_count", count, 3);
        chk("full_pop_head", out_s, 4'd2);
        in_valid = 1'b0;
        step();
        chk("dr_head3", out_s, 4'd3);
        step();
        chk("dr_head4", out_s, 4'd4);
        step();
        chk("dr_empty", out_valid, 0);
        chk("drop_sticky", drop, 1);
        out_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("rst_clr_drop", drop, 0);
        step();
        rst = 1'b0;

        // Fill to 2, then 6 cycles of simultaneous push/pop
        in_valid = 1'b1; in_c = 1'b1;
        in_s = 4'hA;
        step();
        in_s = 4'hB;
        step();
        chk("f2_count", count, 2);
        out_ready = 1'b1;
        begin
            logic [3:0] exp_h [6];
            exp_h = '{4'hA, 4'hB, 4'h0, 4'h1, 4'h2, 4'h3};
            for (int i = 0; i < 6; i++) begin
                in_s = 4'(i);
                in_c = i[0];
                #1;
                chk("pp_head", out_s, exp_h[i]);
                step();
                chk("pp_count", count, 2);
            end
        end
        chk("pp_tail_s", out_s, 4'h4);
        chk("pp_tail_c", out_c, 0);
        chk("pp_drop", drop, 0);

        // Mid-operation async reset with count=3
        out_ready = 1'b0;
        in_s = 4'h7; in_c = 1'b0;
        step();
        in_valid = 1'b0;
        chk("pre_rst_count", count, 3);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", count, 0);
        chk("arst_valid", out_valid, 0);
        chk("arst_drop", drop, 0);
        chk("arst_iready", in_ready, 1);
        chk("arst_s", out_s, 0);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_s = 4'h9; in_c = 1'b1;
        step();
        in_valid = 1'b0;
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_s", out_s, 4'h9);
        chk("post_rst_c", out_c, 1);
        chk("post_rst_count", count, 1);
        out_ready = 1'b1;
        step();
        chk("post_rst_pop", count, 0);

        // Carry counter saturation
        rst = 1'b1;
        #1;
        chk("cc_rst", carry_cnt, 0);
        step();
        rst = 1'b0;
        in_valid = 1'b1; in_c = 1'b1; in_s = 4'h1;
        for (int i = 0; i < 300; i++) begin
            step();
        end
        in_valid = 1'b0;
`ifdef ADDER_RESULT_FIFO_CARRY_CNT_EN
        chk("cc_sat", carry_cnt, 255);
`else
        chk("cc_off", carry_cnt, 0);
`endif
        chk("cc_count", count, 1);
        chk("cc_drop", drop, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
